// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag record layout and small opcode helpers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_SLL  = 3'b100,
        OP_SRL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Combinational NOT/AND/OR/XOR selector with negative/zero detection on its output.
module logic_op_comb
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  alu_op_e        op_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [N-1:0]   res_o,
    output logic           neg_o,
    output logic           zero_o
);

    // Non-logic opcodes produce zero so the reserved encoding needs no special path.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_NOT:  res_o = ~a_i;
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

    assign neg_o  = res_o[N-1];
    assign zero_o = (res_o == '0);

endmodule

// File: rtl/logic_op_shift_unit.sv
// Handshaked logic/shift execution unit: single-cycle logic ops, bit-serial shifts, registered NZCV.
module logic_shift_unit
    import alu_pkg::*;
#(
    parameter int N       = 32,
    parameter int SHAMT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    alu_op_e              op_q, op_d;
    logic [N-1:0]         work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]         result_q, result_d;
    flags_t               flags_q, flags_d;

    alu_op_e              op_in;
    logic [SHAMT_W-1:0]   shamt_in;
    logic [N-1:0]         logic_res;
    logic                 logic_neg, logic_zero;
    logic [N-1:0]         shift_next;
    logic                 shift_out;
    logic [N-1:0]         flag_src;
    logic                 src_neg, src_zero;
    logic [N-1:0]         src_res;

    assign op_in    = alu_op_e'(op);
    assign shamt_in = b[SHAMT_W-1:0];

    logic_op_comb #(.N(N)) u_logic (
        .op_i   (op_in),
        .a_i    (a),
        .b_i    (b),
        .res_o  (logic_res),
        .neg_o  (logic_neg),
        .zero_o (logic_zero)
    );

    // OR with zero passes the value through, reusing the block purely for N/Z detection.
    assign flag_src = (state_q == SHIFT) ? shift_next : a;

    logic_op_comb #(.N(N)) u_flags (
        .op_i   (OP_OR),
        .a_i    (flag_src),
        .b_i    ('0),
        .res_o  (src_res),
        .neg_o  (src_neg),
        .zero_o (src_zero)
    );

    always_comb begin
        shift_next = work_q;
        shift_out  = 1'b0;
        case (op_q)
            OP_SLL: begin
                shift_next = {work_q[N-2:0], 1'b0};
                shift_out  = work_q[N-1];
            end
            OP_SRL: begin
                shift_next = {1'b0, work_q[N-1:1]};
                shift_out  = work_q[0];
            end
            OP_SRA: begin
                shift_next = {work_q[N-1], work_q[N-1:1]};
                shift_out  = work_q[0];
            end
            default: begin
                shift_next = work_q;
                shift_out  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op_in;
                    if (is_shift(op_in) && (shamt_in != '0)) begin
                        work_d  = a;
                        cnt_d   = shamt_in;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        if (op_in == OP_RSVD) begin
                            result_d = '0;
                            flags_d  = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
                        end else if (is_shift(op_in)) begin
                            result_d = src_res;
                            flags_d  = '{n: src_neg, z: src_zero, c: 1'b0, v: 1'b0};
                        end else begin
                            result_d = logic_res;
                            flags_d  = '{n: logic_neg, z: logic_zero, c: 1'b0, v: 1'b0};
                        end
                    end
                end
            end
            SHIFT: begin
                work_d = shift_next;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shift_next;
                    flags_d  = '{n: src_neg, z: src_zero, c: shift_out, v: 1'b0};
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NOT;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
